// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_lat_counter
// Description : Loadable down-counter timing the instruction memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_lat_counter #(
  parameter  int MEM_LATENCY = 1,
  localparam int CW          = $clog2(MEM_LATENCY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= CW'(MEM_LATENCY);
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Asserted in the cycle the memory response is on the bus.
  assign done = (r_count == CW'(1));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetches one instruction per PC from a fixed-latency memory and
//               hands it to decode over valid/ready. Optional misaligned-PC
//               trap enabled by defining INSTR_FETCH_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            fetch_misalign
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_instr_valid;
  logic            r_drop;
  logic            r_misalign;

  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic            w_cnt_done;
  logic            w_capture;
  logic            w_release;
  logic            w_drop_set;
  logic            w_drop_clr;
  logic            w_set_misalign;
  logic            w_misaligned;
  logic [XLEN-1:0] w_fetch_addr;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  assign w_misaligned   = (pc[1:0] != 2'b00);
  assign w_fetch_addr   = pc;
  assign fetch_misalign = r_misalign;
`else
  assign w_misaligned   = 1'b0;
  assign w_fetch_addr   = {pc[XLEN-1:2], 2'b00};
  assign fetch_misalign = 1'b0;
`endif

  fetch_lat_counter #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_lat_counter (
    .clk   (clk),
    .reset (reset),
    .load  (w_cnt_load),
    .dec   (w_cnt_dec),
    .done  (w_cnt_done)
  );

  always_comb begin
    w_state_next   = r_state;
    pc_en          = 1'b0;
    imem_rd_en     = 1'b0;
    imem_addr      = '0;
    w_cnt_load     = 1'b0;
    w_cnt_dec      = 1'b0;
    w_capture      = 1'b0;
    w_release      = 1'b0;
    w_drop_set     = 1'b0;
    w_drop_clr     = 1'b0;
    w_set_misalign = 1'b0;
    case (r_state)
      IDLE: begin
        // A misalign trap parks the unit here until reset.
        if (!r_misalign) w_state_next = REQ;
      end
      REQ: begin
        if (w_misaligned) begin
          w_set_misalign = 1'b1;
          w_state_next   = IDLE;
        end else begin
          imem_rd_en   = 1'b1;
          imem_addr    = w_fetch_addr;
          w_cnt_load   = 1'b1;
          w_drop_set   = flush;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_done) begin
          // A flush on the response cycle itself still kills the word.
          if (r_drop || flush) begin
            w_drop_clr   = 1'b1;
            w_state_next = REQ;
          end else begin
            w_capture    = 1'b1;
            w_state_next = HOLD;
          end
        end else begin
          w_drop_set = flush;
        end
      end
      HOLD: begin
        if (flush) begin
          w_release    = 1'b1;
          w_state_next = REQ;
        end else if (instr_ready) begin
          pc_en        = 1'b1;
          w_release    = 1'b1;
          w_state_next = REQ;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_instr       <= XLEN'(NOP_INSTR);
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_req_pc      <= '0;
      r_drop        <= 1'b0;
      r_misalign    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_load) r_req_pc <= pc;
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_pc    <= r_req_pc;
        r_instr_valid <= 1'b1;
      end
      if (w_release) r_instr_valid <= 1'b0;
      if (w_drop_clr) begin
        r_drop <= 1'b0;
      end else if (w_drop_set) begin
        r_drop <= 1'b1;
      end
      if (w_set_misalign) r_misalign <= 1'b1;
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule
`default_nettype wire
